// File: rtl/apb_pkg.sv
// apb_pkg: shared state encoding and width helpers for the APB master bridge.
package apb_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, SETUP = 2'b01, ACCESS = 2'b10, RESP = 2'b11} state_t;
  localparam int ADDR_WDTH_D = 8;
  localparam int SEL_LSB_D = 6;
  localparam int TIMEOUT_D = 16;
  function automatic int cnt_width(input int timeout);
    return timeout > 0 ? $clog2(timeout + 1) : 1;
  endfunction
  localparam int SEL_W = ADDR_WDTH_D - SEL_LSB_D;
  localparam int CNT_W = cnt_width(TIMEOUT_D);
endpackage

// File: rtl/apb_master_bridge_if.sv
// apb_master_bridge_if: request/response side plus APB master bus of the bridge.
interface apb_master_bridge_if #(
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = 8,
  parameter int NUM_SLV = 2
);
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [ADDR_WDTH-1:0] req_addr;
  logic [DATA_WDTH-1:0] req_wdata;
  logic rsp_valid;
  logic [DATA_WDTH-1:0] rsp_rdata;
  logic rsp_err;
  logic [NUM_SLV-1:0] psel;
  logic penable;
  logic pwrite;
  logic [ADDR_WDTH-1:0] paddr;
  logic [DATA_WDTH-1:0] pwdata;
  logic [NUM_SLV*DATA_WDTH-1:0] prdata_bus;
  logic [NUM_SLV-1:0] pready_bus;
  logic [NUM_SLV-1:0] pslverr_bus;
  modport master (
    input req_valid, req_write, req_addr, req_wdata, prdata_bus, pready_bus, pslverr_bus,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
  modport slave (
    output req_valid, req_write, req_addr, req_wdata, prdata_bus, pready_bus, pslverr_bus,
    input req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_wdog_cntr.sv
// apb_wdog_cntr: ACCESS-cycle counter flagging the last cycle before a transfer is aborted.
module apb_wdog_cntr import apb_pkg::*; #(
  parameter int TIMEOUT = TIMEOUT_D,
  parameter int WIDTH = CNT_W
) (
  input logic clk,
  input logic rst,
  input logic clr,
  input logic en,
  output logic expired
);
  logic [WIDTH-1:0] count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count <= '0;
    else count <= clr ? '0 : en ? count + 1'b1 : count;
  end
  assign expired = (TIMEOUT != 0) && (count == WIDTH'(TIMEOUT - 1));
endmodule

// File: rtl/apb_master_bridge.sv
// apb_master_bridge: valid/ready request to multi-slave APB transfer with decode and watchdog.
module apb_master_bridge import apb_pkg::*; #(
  parameter int DATA_WDTH = 32,
  parameter int ADDR_WDTH = ADDR_WDTH_D,
  parameter int NUM_SLV = 2,
  parameter int SEL_LSB = SEL_LSB_D,
  parameter int TIMEOUT = TIMEOUT_D
) (
  input logic pclk,
  input logic preset,
  apb_master_bridge_if.master bus
);
  localparam int SW = ADDR_WDTH - SEL_LSB;
  localparam int CW = cnt_width(TIMEOUT);
  state_t state;
  logic [SW-1:0] idx;
  logic hit_rdy, hit_err, expired;
  logic [DATA_WDTH-1:0] hit_rdata;
  assign idx = bus.req_addr[ADDR_WDTH-1:SEL_LSB];
  assign bus.req_ready = state == IDLE;
  // psel is one-hot during ACCESS, so masking with it selects the addressed slave
  assign hit_rdy = |(bus.pready_bus & bus.psel);
  assign hit_err = |(bus.pslverr_bus & bus.psel);
  always_comb begin
    hit_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++)
      hit_rdata = hit_rdata | (bus.psel[i] ? bus.prdata_bus[i*DATA_WDTH +: DATA_WDTH] : '0);
  end
  apb_wdog_cntr #(.TIMEOUT(TIMEOUT), .WIDTH(CW)) u_wdog (
    .clk(pclk),
    .rst(preset),
    .clr(state == RESP),
    .en(state == ACCESS),
    .expired(expired)
  );
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state <= IDLE;
      bus.psel <= '0;
      bus.penable <= 1'b0;
      bus.pwrite <= 1'b0;
      bus.paddr <= '0;
      bus.pwdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          bus.pwrite <= bus.req_write;
          bus.paddr <= bus.req_addr;
          bus.pwdata <= bus.req_wdata;
          if (32'(idx) < NUM_SLV) begin
            bus.psel <= NUM_SLV'(1) << idx;
            state <= SETUP;
          end else begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_err <= 1'b1;
            bus.rsp_rdata <= '0;
            state <= RESP;
          end
        end
        SETUP: begin
          bus.penable <= 1'b1;
          state <= ACCESS;
        end
        ACCESS: if (hit_rdy || expired) begin
          bus.psel <= '0;
          bus.penable <= 1'b0;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err <= hit_rdy ? hit_err : 1'b1;
          bus.rsp_rdata <= (hit_rdy && !bus.pwrite) ? hit_rdata : '0;
          state <= RESP;
        end
        default: begin
          bus.rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_bridge.sv
// tb_apb_master_bridge: directed transfers against a transaction-timeline model of the bridge.
module tb_apb_master_bridge;
  logic pclk = 1'b0;
  logic preset = 1'b1;
  always #5 pclk = ~pclk;
  apb_master_bridge_if #(.DATA_WDTH(32), .ADDR_WDTH(8), .NUM_SLV(2)) bus ();
  apb_master_bridge #(.DATA_WDTH(32), .ADDR_WDTH(8), .NUM_SLV(2), .SEL_LSB(6), .TIMEOUT(16)) dut (
    .pclk(pclk),
    .preset(preset),
    .bus(bus)
  );
  int vectors = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge pclk) cyc <= cyc + 1;
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  // two slave models: 64-byte memories, offsets >= 50 answer pslverr, pready on ACCESS cycle ready_at
  logic [7:0] smem [2][64];
  logic [1:0] pready_r, pslverr_r;
  logic [31:0] prdata_r [2];
  int acc_k [2];
  int ready_at = 2;
  logic noise = 1'b0;
  logic [5:0] soff;
  assign soff = bus.paddr[5:0];
  always @(posedge pclk) noise <= ~noise;
  always @(posedge pclk or posedge preset) begin
    if (preset) begin
      pready_r <= '0;
      acc_k[0] <= 0;
      acc_k[1] <= 0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (bus.psel[i] && bus.penable && !pready_r[i]) begin
          acc_k[i] <= acc_k[i] + 1;
          if (acc_k[i] + 2 == ready_at) begin
            pready_r[i] <= 1'b1;
            pslverr_r[i] <= soff >= 6'd50;
            if (soff >= 6'd50) prdata_r[i] <= '0;
            else if (bus.pwrite) begin
              for (int b = 0; b < 4; b++) smem[i][soff + b] <= bus.pwdata[8*b +: 8];
              prdata_r[i] <= '0;
            end else prdata_r[i] <= {smem[i][soff + 3], smem[i][soff + 2], smem[i][soff + 1], smem[i][soff]};
          end
        end else begin
          pready_r[i] <= 1'b0;
          acc_k[i] <= 0;
        end
      end
    end
  end
  // unselected slaves drive toggling garbage that the bridge must ignore
  always_comb begin
    bus.pready_bus = '0;
    bus.pslverr_bus = '0;
    bus.prdata_bus = '0;
    for (int i = 0; i < 2; i++) begin
      bus.pready_bus[i] = bus.psel[i] ? pready_r[i] : noise;
      bus.pslverr_bus[i] = bus.psel[i] ? pslverr_r[i] : noise;
      bus.prdata_bus[i*32 +: 32] = bus.psel[i] ? prdata_r[i] : (32'hDEADBEEF ^ {32{noise}});
    end
  end
  // transaction model: timeline relative to the accept cycle t_acc, response at t_acc + t_len
  logic [7:0] ref_mem [256];
  bit active = 0;
  int t_acc, t_len;
  bit t_dec;
  logic [1:0] t_sel;
  logic t_err, t_w;
  logic [31:0] t_rd, t_wd;
  logic [7:0] t_addr;
  logic [7:0] e_paddr;
  logic [31:0] e_pwdata, h_rd;
  logic e_pwrite, h_err;
  int pen_cnt, lat_seen;
  logic [1:0] psel_seen;
  int r;
  logic exp_ready, exp_pen, exp_rv;
  logic [1:0] exp_psel;
  always @(negedge pclk) begin
    if (!preset) begin
      r = active ? cyc - t_acc : -1;
      if (active && r == 1) begin
        e_paddr = t_addr;
        e_pwdata = t_wd;
        e_pwrite = t_w;
      end
      if (active && r == t_len) begin
        h_err = t_err;
        h_rd = t_rd;
      end
      exp_ready = !active || r <= 0 || r > t_len;
      exp_psel = (active && !t_dec && r >= 1 && r <= t_len - 1) ? t_sel : 2'b00;
      exp_pen = active && !t_dec && r >= 2 && r <= t_len - 1;
      exp_rv = active && r == t_len;
      if (bus.penable) pen_cnt++;
      psel_seen |= bus.psel;
      if (bus.rsp_valid) lat_seen = r;
      check("req_ready", bus.req_ready, exp_ready);
      check("psel", bus.psel, exp_psel);
      check("penable", bus.penable, exp_pen);
      check("rsp_valid", bus.rsp_valid, exp_rv);
      check("rsp_err", bus.rsp_err, h_err);
      check("rsp_rdata", bus.rsp_rdata, h_rd);
      check("paddr", bus.paddr, e_paddr);
      check("pwdata", bus.pwdata, e_pwdata);
      check("pwrite", bus.pwrite, e_pwrite);
    end
  end
  task automatic start_req(input logic w, input logic [7:0] a, input logic [31:0] wd, input int rdy);
    int idx, off;
    bit tmo;
    #1;
    idx = int'(a) >> 6;
    off = int'(a) & 63;
    ready_at = rdy;
    t_acc = cyc;
    t_w = w;
    t_addr = a;
    t_wd = wd;
    t_dec = idx >= 2;
    t_sel = t_dec ? 2'b00 : 2'(1 << idx);
    tmo = !t_dec && (rdy == 0 || rdy > 16);
    t_len = t_dec ? 1 : tmo ? 18 : 2 + rdy;
    t_err = t_dec || tmo || off >= 50;
    t_rd = (w || t_err) ? 32'h0 : {ref_mem[a + 3], ref_mem[a + 2], ref_mem[a + 1], ref_mem[a]};
    if (w && !t_err) for (int b = 0; b < 4; b++) ref_mem[a + b] = wd[8*b +: 8];
    pen_cnt = 0;
    psel_seen = '0;
    lat_seen = -1;
    active = 1;
    bus.req_valid = 1'b1;
    bus.req_write = w;
    bus.req_addr = a;
    bus.req_wdata = wd;
    @(negedge pclk);
    #1 bus.req_valid = 1'b0;
  endtask
  task automatic do_req(input logic w, input logic [7:0] a, input logic [31:0] wd, input int rdy);
    start_req(w, a, wd, rdy);
    repeat (t_len) @(negedge pclk);
  endtask
  task automatic clear_model();
    active = 0;
    e_paddr = '0;
    e_pwdata = '0;
    e_pwrite = 1'b0;
    h_err = 1'b0;
    h_rd = '0;
  endtask
  initial begin
    #50000;
    $display("FAIL sim_limit: time %0t reached without finishing", $time);
    $fatal(1, "simulation time limit");
  end
  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < 64; i++) begin
      smem[0][i] = 8'h00;
      smem[1][i] = 8'h00;
    end
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    clear_model();
    repeat (3) @(negedge pclk);
    check("reset_psel", bus.psel, 2'b00);
    check("reset_penable", bus.penable, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check("reset_rsp_rdata", bus.rsp_rdata, 32'h0);
    check("reset_paddr", bus.paddr, 8'h00);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("idle_req_ready", bus.req_ready, 1'b1);
    do_req(1'b1, 8'h04, 32'hA1B2C3D4, 2);
    check("wr0_latency", lat_seen, 4);
    check("wr0_psel_seen", psel_seen, 2'b01);
    check("wr0_err", bus.rsp_err, 1'b0);
    check("wr0_mem_bytes", {smem[0][4], smem[0][5], smem[0][6], smem[0][7]}, 32'hD4C3B2A1);
    do_req(1'b0, 8'h04, 32'h0, 2);
    check("rd0_rdata", bus.rsp_rdata, 32'hA1B2C3D4);
    check("rd0_latency", lat_seen, 4);
    do_req(1'b0, 8'h7F, 32'h0, 2);
    check("oob_psel_seen", psel_seen, 2'b10);
    check("oob_err", bus.rsp_err, 1'b1);
    check("oob_rdata", bus.rsp_rdata, 32'h0);
    do_req(1'b1, 8'h48, 32'h11223344, 3);
    do_req(1'b0, 8'h48, 32'h0, 5);
    check("rd1_rdata", bus.rsp_rdata, 32'h11223344);
    do_req(1'b0, 8'h80, 32'h0, 2);
    check("dec_latency", lat_seen, 1);
    check("dec_psel_seen", psel_seen, 2'b00);
    check("dec_err", bus.rsp_err, 1'b1);
    do_req(1'b1, 8'hC4, 32'hFFFF0000, 2);
    do_req(1'b0, 8'h08, 32'h0, 0);
    check("tmo_access_cycles", pen_cnt, 16);
    check("tmo_latency", lat_seen, 18);
    check("tmo_err", bus.rsp_err, 1'b1);
    do_req(1'b0, 8'h04, 32'h0, 16);
    check("tie_access_cycles", pen_cnt, 16);
    check("tie_err", bus.rsp_err, 1'b0);
    check("tie_rdata", bus.rsp_rdata, 32'hA1B2C3D4);
    do_req(1'b0, 8'h10, 32'h0, 17);
    do_req(1'b0, 8'h10, 32'h0, 2);
    start_req(1'b0, 8'h08, 32'h0, 0);
    repeat (3) @(negedge pclk);
    @(posedge pclk);
    #2 preset = 1'b1;
    clear_model();
    #1;
    check("rst_mid_psel", bus.psel, 2'b00);
    check("rst_mid_penable", bus.penable, 1'b0);
    check("rst_mid_rsp_valid", bus.rsp_valid, 1'b0);
    @(negedge pclk);
    @(negedge pclk);
    #1 preset = 1'b0;
    repeat (2) @(negedge pclk);
    check("post_rst_req_ready", bus.req_ready, 1'b1);
    do_req(1'b0, 8'h4C, 32'h0, 0);
    check("post_rst_tmo_cycles", pen_cnt, 16);
    do_req(1'b0, 8'h04, 32'h0, 2);
    check("post_rst_rdata", bus.rsp_rdata, 32'hA1B2C3D4);
    check("post_rst_latency", lat_seen, 4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
